// File: rtl/dense_latency_if.sv
// Streaming port bundle for dense_latency_layer.
// Handshake: valid-only, no ready. A vector is transferred on every rising clk
// edge where in_valid=1 (out_valid=1 on the result side). The sink must accept
// every such vector, because there is no backpressure.
interface dense_latency_if #(
    parameter int WIDTH       = 16,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 8
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] input_data  [0:INPUT_SIZE-1];
    logic                    out_valid;
    logic signed [WIDTH-1:0] output_data [0:OUTPUT_SIZE-1];

    // Producer of input vectors, consumer of results.
    modport master (
        output in_valid,
        output input_data,
        input  out_valid,
        input  output_data
    );

    // The dense layer itself.
    modport slave (
        input  in_valid,
        input  input_data,
        output out_valid,
        output output_data
    );
endinterface

// File: rtl/dense_latency_layer.sv
// Fixed-latency, fully parallel fixed-point dense layer: y = W*x + b.
// Three register stages (products, accumulation, shift/reduce) and one
// vector per clock. Optional macro DENSE_SATURATE_EN clamps the result to the
// WIDTH-bit range; without it the result wraps to its low WIDTH bits.
module dense_latency_layer #(
    parameter int WIDTH       = 16,
    parameter int NFRAC       = 12,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    dense_latency_if.slave          bus,
    input  logic signed [WIDTH-1:0] weights [0:OUTPUT_SIZE-1][0:INPUT_SIZE-1],
    input  logic signed [WIDTH-1:0] biases  [0:OUTPUT_SIZE-1]
);

    // Full-precision product width and overflow-free accumulator width.
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + $clog2(INPUT_SIZE + 1);

    // Largest and smallest representable WIDTH-bit results, at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    // Stage 1 state: products and biases captured with the input vector.
    logic                    v1;
    logic signed [PW-1:0]    prod_q [0:OUTPUT_SIZE-1][0:INPUT_SIZE-1];
    logic signed [WIDTH-1:0] bias_q [0:OUTPUT_SIZE-1];

    // Stage 2 state: per-neuron accumulators.
    logic                    v2;
    logic signed [AW-1:0]    acc_d  [0:OUTPUT_SIZE-1];
    logic signed [AW-1:0]    acc_q  [0:OUTPUT_SIZE-1];

    // Stage 3 state: reduced results.
    logic                    v3;
    logic signed [AW-1:0]    shifted [0:OUTPUT_SIZE-1];
    logic signed [WIDTH-1:0] reduced [0:OUTPUT_SIZE-1];
    logic signed [WIDTH-1:0] out_q   [0:OUTPUT_SIZE-1];

    // Exact signed product: both operands are sign-extended to the product
    // width first so the multiply never truncates.
    function automatic logic signed [PW-1:0] mul_full(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax = {{WIDTH{a[WIDTH-1]}}, a};
        bx = {{WIDTH{b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Stage 1: capture every product and the biases; data always loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            for (int o = 0; o < OUTPUT_SIZE; o++) begin
                bias_q[o] <= '0;
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    prod_q[o][i] <= '0;
                end
            end
        end else begin
            v1 <= bus.in_valid;
            for (int o = 0; o < OUTPUT_SIZE; o++) begin
                bias_q[o] <= biases[o];
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    prod_q[o][i] <= mul_full(bus.input_data[i], weights[o][i]);
                end
            end
        end
    end

    // Stage 2 combinational sum: bias aligned to the product binary point
    // (shifted left by NFRAC), then every sign-extended product added in.
    always_comb begin
        for (int o = 0; o < OUTPUT_SIZE; o++) begin
            acc_d[o] = {{(AW-WIDTH){bias_q[o][WIDTH-1]}}, bias_q[o]} <<< NFRAC;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                acc_d[o] = acc_d[o] + {{(AW-PW){prod_q[o][i][PW-1]}}, prod_q[o][i]};
            end
        end
    end

    // Stage 2: register the accumulators and advance the valid pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2 <= 1'b0;
            for (int o = 0; o < OUTPUT_SIZE; o++) begin
                acc_q[o] <= '0;
            end
        end else begin
            v2 <= v1;
            for (int o = 0; o < OUTPUT_SIZE; o++) begin
                acc_q[o] <= acc_d[o];
            end
        end
    end

    // Stage 3 combinational reduce: arithmetic shift back to NFRAC fractional
    // bits (floor toward -inf), then squeeze into WIDTH bits.
    always_comb begin
        for (int o = 0; o < OUTPUT_SIZE; o++) begin
            shifted[o] = acc_q[o] >>> NFRAC;
`ifdef DENSE_SATURATE_EN
            if (shifted[o] > SAT_MAX) begin
                reduced[o] = SAT_MAX[WIDTH-1:0];
            end else if (shifted[o] < SAT_MIN) begin
                reduced[o] = SAT_MIN[WIDTH-1:0];
            end else begin
                reduced[o] = shifted[o][WIDTH-1:0];
            end
`else
            reduced[o] = shifted[o][WIDTH-1:0];
`endif
        end
    end

`ifndef DENSE_SATURATE_EN
    // In wrap mode the high result bits and the bound constants are simply
    // discarded; fold them into one sink so the intent is explicit.
    logic unused_hi;
    always_comb begin
        unused_hi = ^{SAT_MAX, SAT_MIN};
        for (int o = 0; o < OUTPUT_SIZE; o++) begin
            unused_hi = unused_hi ^ (^shifted[o][AW-1:WIDTH]);
        end
    end
`endif

    // Stage 3: results load only with a valid vector, so outputs hold the
    // last result while out_valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3 <= 1'b0;
            for (int o = 0; o < OUTPUT_SIZE; o++) begin
                out_q[o] <= '0;
            end
        end else begin
            v3 <= v2;
            if (v2) begin
                for (int o = 0; o < OUTPUT_SIZE; o++) begin
                    out_q[o] <= reduced[o];
                end
            end
        end
    end

    // Drive the result side of the bundle from the stage 3 registers.
    always_comb begin
        bus.out_valid = v3;
        for (int o = 0; o < OUTPUT_SIZE; o++) begin
            bus.output_data[o] = out_q[o];
        end
    end

endmodule

// File: tb/tb_dense_latency_layer.sv
// Bench for dense_latency_layer (WIDTH=16, NFRAC=12, INPUT_SIZE=4, OUTPUT_SIZE=2).
// Directed table vectors, hand-written streaming/reset sequences and random
// traffic checked against an integer-arithmetic reference model.
module tb_dense_latency_layer;
    localparam int W  = 16;
    localparam int NF = 12;
    localparam int NI = 4;
    localparam int NO = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic signed [W-1:0] weights [0:NO-1][0:NI-1];
    logic signed [W-1:0] biases  [0:NO-1];

    dense_latency_if #(.WIDTH(W), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO)) bus ();

    dense_latency_layer #(
        .WIDTH(W), .NFRAC(NF), .INPUT_SIZE(NI), .OUTPUT_SIZE(NO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .weights (weights),
        .biases  (biases)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int ecount = 0;
    logic [NO*W-1:0] exp_q [$];
    int              due_q [$];
    logic [NO*W-1:0] last_out;

    logic signed [W-1:0] cur_x [NI];
    logic signed [W-1:0] cur_w [NO][NI];
    logic signed [W-1:0] cur_b [NO];

    typedef struct {
        logic signed [W-1:0] x [NI];
        logic signed [W-1:0] w [NO][NI];
        logic signed [W-1:0] b [NO];
        logic signed [W-1:0] y [NO];
    } vec_t;
    vec_t tv [3];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, ecount);
        end
    endtask

    function automatic logic [NO*W-1:0] pack_out();
        logic [NO*W-1:0] res;
        for (int o = 0; o < NO; o++) res[(NO-1-o)*W +: W] = bus.output_data[o];
        return res;
    endfunction

    // Reference: y[o] = floor((sum x*w + b*2^NF) / 2^NF), then wrap or clamp.
    function automatic logic [NO*W-1:0] model();
        logic [NO*W-1:0] res;
        for (int o = 0; o < NO; o++) begin
            longint acc;
            longint r;
            acc = longint'(cur_b[o]) * (longint'(1) <<< NF);
            for (int i = 0; i < NI; i++) acc += longint'(cur_x[i]) * longint'(cur_w[o][i]);
            r = acc >>> NF;
`ifdef DENSE_SATURATE_EN
            if (r > (longint'(1) <<< (W-1)) - 1) r = (longint'(1) <<< (W-1)) - 1;
            else if (r < -(longint'(1) <<< (W-1))) r = -(longint'(1) <<< (W-1));
`endif
            res[(NO-1-o)*W +: W] = r[W-1:0];
        end
        return res;
    endfunction

    // One clock: advance, then compare at the falling edge.
    task automatic step();
        @(posedge clk);
        ecount++;
        @(negedge clk);
        if (due_q.size() > 0 && due_q[0] == ecount) begin
            logic [NO*W-1:0] e;
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("out_valid_hi", 64'(bus.out_valid), 64'd1);
            check("output_data", 64'(pack_out()), 64'(e));
            last_out = e;
        end else begin
            check("out_valid_lo", 64'(bus.out_valid), 64'd0);
            check("output_hold", 64'(pack_out()), 64'(last_out));
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic signed [W-1:0] rnd_val();
        logic [W-1:0] v;
        if ($urandom_range(0, 1) == 1) v = W'($urandom_range(0, 65535));
        else v = W'($urandom_range(0, 8191)) - W'(4096);
        return v;
    endfunction

    task automatic randomize_cur();
        for (int i = 0; i < NI; i++) cur_x[i] = rnd_val();
        for (int o = 0; o < NO; o++) begin
            cur_b[o] = rnd_val();
            for (int i = 0; i < NI; i++) cur_w[o][i] = rnd_val();
        end
    endtask

    task automatic apply_cur(input logic valid);
        bus.in_valid = valid;
        for (int i = 0; i < NI; i++) bus.input_data[i] = cur_x[i];
        for (int o = 0; o < NO; o++) begin
            biases[o] = cur_b[o];
            for (int i = 0; i < NI; i++) weights[o][i] = cur_w[o][i];
        end
    endtask

    task automatic submit_exp(input logic [NO*W-1:0] e);
        apply_cur(1'b1);
        due_q.push_back(ecount + 3);
        exp_q.push_back(e);
    endtask

    task automatic submit_model();
        submit_exp(model());
    endtask

    // Idle cycle with garbage on the data and coefficient ports.
    task automatic idle();
        randomize_cur();
        apply_cur(1'b0);
    endtask

    task automatic drain_check(input string name);
        repeat (5) step();
        check(name, 64'(due_q.size()), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [NO*W-1:0] e;

        // Directed table: basic MAC, floor truncation, overflow.
        tv[0].x = '{16'sd4096, 16'sd8192, -16'sd4096, 16'sd2048};
        tv[0].w = '{'{16'sd4096, 16'sd0, 16'sd0, 16'sd0},
                    '{16'sd4096, 16'sd4096, 16'sd4096, 16'sd4096}};
        tv[0].b = '{16'sd0, 16'sd2048};
        tv[0].y = '{16'sd4096, 16'sd12288};
        tv[1].x = '{-16'sd1, 16'sd0, 16'sd0, 16'sd0};
        tv[1].w = '{'{16'sd2048, 16'sd0, 16'sd0, 16'sd0},
                    '{16'sd0, 16'sd0, 16'sd0, 16'sd0}};
        tv[1].b = '{16'sd0, 16'sd0};
        tv[1].y = '{-16'sd1, 16'sd0};
        tv[2].x = '{16'sd28672, 16'sd28672, 16'sd28672, 16'sd28672};
        tv[2].w = '{'{16'sd28672, 16'sd28672, 16'sd28672, 16'sd28672},
                    '{16'sd28672, 16'sd28672, 16'sd28672, 16'sd28672}};
        tv[2].b = '{16'sd0, 16'sd0};
`ifdef DENSE_SATURATE_EN
        tv[2].y = '{16'sd32767, 16'sd32767};
`else
        tv[2].y = '{16'sd16384, 16'sd16384};
`endif

        // Reset held low with clock running.
        reset = 1'b0;
        last_out = '0;
        idle();
        repeat (3) step();
        reset = 1'b1;

        // Table vectors, each in isolation.
        for (int k = 0; k < 3; k++) begin
            cur_x = tv[k].x;
            cur_w = tv[k].w;
            cur_b = tv[k].b;
            for (int o = 0; o < NO; o++) e[(NO-1-o)*W +: W] = tv[k].y[o];
            submit_exp(e);
            step();
            idle();
            repeat (4) step();
        end

        // Streaming: 5 back-to-back vectors, then a gapped pattern.
        for (int k = 0; k < 5; k++) begin
            randomize_cur();
            submit_model();
            step();
        end
        idle();
        drain_check("drain_burst");
        randomize_cur(); submit_model(); step();
        idle(); step();
        randomize_cur(); submit_model(); step();
        idle(); step(); step();
        randomize_cur(); submit_model(); step();
        idle();
        drain_check("drain_gaps");

        // Random traffic with coefficients changing every vector.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 99) < 65) begin
                randomize_cur();
                submit_model();
            end else begin
                idle();
            end
            step();
        end
        idle();
        drain_check("drain_random");

        // Reset mid-stream with two vectors in flight.
        randomize_cur(); submit_model(); step();
        randomize_cur(); submit_model(); step();
        idle();
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_data", 64'(pack_out()), 64'd0);
        exp_q.delete();
        due_q.delete();
        last_out = '0;
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        randomize_cur(); submit_model(); step();
        idle();
        drain_check("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
